// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32I/RV64I subset core: add/sub/and/or/addi, XLEN-wide load/store, beq/bne.
// Define BRANCH_EXT_EN to also accept blt/bge as signed compares.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_FETCH  | imem_req high at PC, wait for imem_ready, latch instruction
// S_DECODE | read rs1/rs2, build immediate, reject unsupported encodings
// S_EXEC   | ALU/address compute; branches resolve and retire here
// S_MEM    | dmem_req held stable until dmem_ready
// S_WB     | write rd, advance PC, retire
// S_HALT   | stopped until reset
module rv_multicycle_core #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic            retire,
  output logic            halted,
  output logic [XLEN-1:0] dbg_pc
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [2:0]      LS_F3   = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] rs1_val, rs2_val, imm, res;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  logic is_alu_r, is_addi, is_load, is_store, is_branch, br_f3_ok, legal;

`ifdef BRANCH_EXT_EN
  assign br_f3_ok = funct3 inside {3'b000, 3'b001, 3'b100, 3'b101};
`else
  assign br_f3_ok = funct3 inside {3'b000, 3'b001};
`endif

  assign is_alu_r  = (opcode == 7'b0110011) &&
                     (((funct7 == 7'b0000000) && (funct3 inside {3'b000, 3'b110, 3'b111})) ||
                      ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
  assign is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_load   = (opcode == 7'b0000011) && (funct3 == LS_F3);
  assign is_store  = (opcode == 7'b0100011) && (funct3 == LS_F3);
  assign is_branch = (opcode == 7'b1100011) && br_f3_ok;
  assign legal     = is_alu_r | is_addi | is_load | is_store | is_branch;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_dec;
  assign imm_i   = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s   = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b   = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_dec = is_store ? imm_s : (is_branch ? imm_b : imm_i);

  logic [XLEN-1:0] rf_rs1, rf_rs2;
  assign rf_rs1 = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rf_rs2 = (rs2 == 5'd0) ? '0 : regs[rs2];

  // Loads and stores fall through to the add path, giving rs1 + imm as the address.
  logic [XLEN-1:0] alu_b, alu_out;
  logic            br_taken;
  assign alu_b = is_alu_r ? rs2_val : imm;

  always_comb begin
    alu_out = rs1_val + alu_b;
    if (is_alu_r) begin
      case (funct3)
        3'b110:  alu_out = rs1_val | rs2_val;
        3'b111:  alu_out = rs1_val & rs2_val;
        default: alu_out = funct7[5] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
      endcase
    end
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      default: br_taken = 1'b0;
    endcase
  end

  assign imem_addr = pc;
  assign dbg_pc    = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      rs1_val    <= '0;
      rs2_val    <= '0;
      imm        <= '0;
      res        <= '0;
      imem_req   <= 1'b1;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      retire     <= 1'b0;
      halted     <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: if (imem_ready) begin
          ir       <= imem_rdata;
          imem_req <= 1'b0;
          state    <= S_DECODE;
        end
        S_DECODE: begin
          rs1_val <= rf_rs1;
          rs2_val <= rf_rs2;
          imm     <= imm_dec;
          if (legal) begin
            state <= S_EXEC;
          end else begin
            halted <= 1'b1;
            state  <= S_HALT;
          end
        end
        S_EXEC: begin
          if (is_branch) begin
            pc       <= br_taken ? (pc + imm) : (pc + PC_STEP);
            retire   <= 1'b1;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end else if (is_load || is_store) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= alu_out;
            dmem_wdata <= rs2_val;
            state      <= S_MEM;
          end else begin
            res   <= alu_out;
            state <= S_WB;
          end
        end
        S_MEM: if (dmem_ready) begin
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          if (is_store) begin
            pc       <= pc + PC_STEP;
            retire   <= 1'b1;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end else begin
            res   <= dmem_rdata;
            state <= S_WB;
          end
        end
        S_WB: begin
          if (rd != 5'd0) regs[rd] <= res;
          pc       <= pc + PC_STEP;
          retire   <= 1'b1;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT: halted <= 1'b1;
        default: begin
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          halted   <= 1'b1;
          state    <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Directed bench for rv_multicycle_core (XLEN=64): cycle timing, memory handshakes, branches, reset abort.
// Cycle 0 is the first cycle after reset deasserts; retire is high in the cycle after an instruction completes.
module tb_rv_multicycle_core;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_rdata;
  logic        dmem_ready;
  logic        retire;
  logic        halted;
  logic [63:0] dbg_pc;

  logic [31:0] prog [0:63];
  int vectors = 0;
  int miscompares = 0;

  rv_multicycle_core #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .retire(retire), .halted(halted), .dbg_pc(dbg_pc)
  );

  assign imem_rdata = prog[imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic clear_prog;
    for (int i = 0; i < 64; i++) prog[i] = 32'h00000013;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_store(input string tag, input logic [63:0] addr, input logic [63:0] data);
    int n;
    n = 0;
    while (dmem_req !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk1({tag, "_req"}, dmem_req, 1'b1);
    chk1({tag, "_we"}, dmem_we, 1'b1);
    chk({tag, "_addr"}, dmem_addr, addr);
    chk({tag, "_wdata"}, dmem_wdata, data);
    tick();
  endtask

  task automatic wait_fetch(input string tag, input logic [63:0] addr);
    int n;
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr === addr) && n < 60) begin
      tick();
      n++;
    end
    chk(tag, imem_addr, addr);
  endtask

  initial begin
    reset      = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 64'h0;

    // Phase A: ALU chain, delayed store/load, x0 discard, sub/and/or
    clear_prog();
    prog[0]  = 32'h00500093;  // addi x1,x0,5
    prog[1]  = 32'h00700113;  // addi x2,x0,7
    prog[2]  = 32'h002081B3;  // add  x3,x1,x2
    prog[3]  = 32'h00303423;  // sd   x3,8(x0)
    prog[4]  = 32'h00803203;  // ld   x4,8(x0)
    prog[5]  = 32'h00403823;  // sd   x4,16(x0)
    prog[6]  = 32'h00900013;  // addi x0,x0,9
    prog[7]  = 32'h000002B3;  // add  x5,x0,x0
    prog[8]  = 32'h00503C23;  // sd   x5,24(x0)
    prog[9]  = 32'h40208333;  // sub  x6,x1,x2
    prog[10] = 32'h0020F3B3;  // and  x7,x1,x2
    prog[11] = 32'h0020E433;  // or   x8,x1,x2
    prog[12] = 32'h02603023;  // sd   x6,32(x0)
    prog[13] = 32'h02703423;  // sd   x7,40(x0)
    prog[14] = 32'h02803823;  // sd   x8,48(x0)
    do_reset();

    chk1("rst_imem_req", imem_req, 1'b1);
    chk("rst_imem_addr", imem_addr, 64'h0);
    chk("rst_dbg_pc", dbg_pc, 64'h0);
    chk1("rst_retire", retire, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_dmem_req", dmem_req, 1'b0);
    chk1("rst_dmem_we", dmem_we, 1'b0);

    for (int c = 1; c <= 12; c++) begin
      tick();
      chk1($sformatf("retire_c%0d", c), retire, (c % 4) == 0);
      if (c == 4) chk("pc_c4", dbg_pc, 64'h4);
    end
    chk("fetch_c12", imem_addr, 64'hC);

    tick(); tick(); tick();  // c15: first MEM cycle of sd
    chk1("sd_req_c15", dmem_req, 1'b1);
    chk1("sd_we_c15", dmem_we, 1'b1);
    chk1("sd_noimem_c15", imem_req, 1'b0);
    chk("sd_addr_c15", dmem_addr, 64'h8);
    chk("sd_x3_c15", dmem_wdata, 64'd12);
    tick();
    chk("sd_addr_c16", dmem_addr, 64'h8);
    chk("sd_x3_c16", dmem_wdata, 64'd12);
    tick();
    chk1("sd_req_c17", dmem_req, 1'b1);
    chk("sd_x3_c17", dmem_wdata, 64'd12);
    dmem_ready = 1'b1;
    tick();  // c18
    chk1("sd_retire_c18", retire, 1'b1);
    chk1("sd_req_off_c18", dmem_req, 1'b0);
    chk1("sd_we_off_c18", dmem_we, 1'b0);
    chk("fetch_c18", imem_addr, 64'h10);
    dmem_ready = 1'b0;
    dmem_rdata = 64'd12;

    tick(); tick(); tick();  // c21: first MEM cycle of ld
    chk1("ld_req_c21", dmem_req, 1'b1);
    chk1("ld_we_c21", dmem_we, 1'b0);
    chk("ld_addr_c21", dmem_addr, 64'h8);
    tick();
    tick();
    dmem_ready = 1'b1;
    tick();  // c24: WB
    chk1("ld_retire_c24", retire, 1'b0);
    chk1("ld_req_off_c24", dmem_req, 1'b0);
    tick();  // c25
    chk1("ld_retire_c25", retire, 1'b1);
    chk("fetch_c25", imem_addr, 64'h14);

    wait_store("sd_x4", 64'd16, 64'd12);
    wait_store("x0_discard", 64'd24, 64'd0);
    wait_store("sub", 64'd32, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_store("and", 64'd40, 64'd5);
    wait_store("or", 64'd48, 64'd7);

    // Phase B: fetch stall, beq/bne, blt
    dmem_ready = 1'b1;
    imem_ready = 1'b0;
    clear_prog();
    prog[0] = 32'hFFF00093;  // addi x1,x0,-1
    prog[1] = 32'h00300113;  // addi x2,x0,3
    prog[4] = 32'hFE108CE3;  // beq  x1,x1,-8
    prog[5] = 32'h0020C663;  // blt  x1,x2,+12
    do_reset();
    tick(); tick();
    chk1("fstall_req", imem_req, 1'b1);
    chk("fstall_pc", dbg_pc, 64'h0);
    imem_ready = 1'b1;

    wait_fetch("reach_beq", 64'h10);
    tick(); tick(); tick();
    chk("beq_target", imem_addr, 64'h08);
    chk1("beq_retire", retire, 1'b1);
    prog[4] = 32'hFE109CE3;  // bne x1,x1,-8
    wait_fetch("reach_bne", 64'h10);
    tick(); tick(); tick();
    chk("bne_fallthru", imem_addr, 64'h14);
    chk1("bne_retire", retire, 1'b1);

    tick(); tick(); tick();
`ifdef BRANCH_EXT_EN
    chk("blt_target", imem_addr, 64'h20);
    chk1("blt_retire", retire, 1'b1);
    chk1("blt_not_halted", halted, 1'b0);
`else
    chk1("blt_halted", halted, 1'b1);
    chk1("blt_no_retire", retire, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("halt_no_imem", imem_req, 1'b0);
    end
    chk("halt_pc_frozen", dbg_pc, 64'h14);
    chk1("halt_sticky", halted, 1'b1);
`endif

    // Phase C: reset abandons a stalled store; registers come back zero
    dmem_ready = 1'b0;
    clear_prog();
    prog[0] = 32'h00500093;  // addi x1,x0,5
    prog[1] = 32'h00103423;  // sd   x1,8(x0)
    do_reset();
    wait_store("pre_rst_sd", 64'd8, 64'd5);
    chk1("mem_stalled", dmem_req, 1'b1);
    reset      = 1'b1;
    dmem_ready = 1'b1;
    prog[0]    = 32'h00103423;  // sd x1,8(x0) now first
    tick();
    chk1("abort_dmem_req", dmem_req, 1'b0);
    chk1("abort_dmem_we", dmem_we, 1'b0);
    chk1("abort_imem_req", imem_req, 1'b1);
    chk("abort_pc", dbg_pc, 64'h0);
    chk1("abort_retire", retire, 1'b0);
    reset = 1'b0;
    wait_store("regs_zero", 64'd8, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
